// File: rtl/fetch_pc_gen_pkg.sv
// fetch_pc_gen_pkg: shared constants and line-alignment helper for the fetch PC generator
package fetch_pc_gen_pkg;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [31:0] RESET_PC = 32'hbfc00000;
  localparam logic SRAM_READ = 1'b0;
  localparam logic [1:0] LINE_SIZE = 2'b11;
  localparam logic [31:0] ZERO_WORD = 32'h0;
  function automatic logic [31:0] line_align(input logic [31:0] pc, input int p);
    logic [31:0] m;
    m = ((32'h1 << p) - 32'h1) & ~32'h3;
    return pc & ~m;
  endfunction
endpackage

// File: rtl/fetch_inflight_fifo.sv
// fetch_inflight_fifo: in-order request tracker with per-entry stale bit and kill_all
module fetch_inflight_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             din_dead,
  input  logic             pop,
  input  logic             kill_all,
  output logic [WIDTH-1:0] dout,
  output logic             dout_dead,
  output logic [2:0]       count
);
  logic [WIDTH-1:0] mem [4];
  logic [3:0] dead;
  logic [1:0] wp, rp;
  logic pop_ok;
  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction
  assign pop_ok = pop & (count != 3'd0);
  assign dout = mem[rp];
  assign dout_dead = dead[rp];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) mem[k] <= '0;
      dead <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (kill_all) dead <= '1;
      if (push) begin
        mem[wp] <= din;
        dead[wp] <= din_dead;
        wp <= nxt(wp);
      end
      if (pop_ok) rp <= nxt(rp);
      count <= count + 3'(push) - 3'(pop_ok);
    end
  end
endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: IF-stage PC generator with in-order in-flight tracking; `PCG_PERF_CNT_EN adds stall/redirect counters
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int FETCH_WIDTH = 4,
  parameter int MAX_INFLIGHT = 2,
  parameter int INDEX_W = 12,
  parameter logic [31:0] START_PC = RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   inst_req,
  output logic                   inst_wr,
  output logic [1:0]             inst_size,
  output logic [INDEX_W-1:0]     inst_index,
  output logic [31:0]            inst_wdata,
  input  logic                   inst_index_ok,
  input  logic                   inst_data_ok,
  input  logic                   ID_stopFetch_i,
  input  logic [31:0]            DSP_predictPC_i,
  input  logic                   DSP_needDelaySlot_i,
  input  logic                   SBA_flush_w_i,
  input  logic                   BSC_isDiffRes_w_i,
  input  logic [31:0]            BSC_correctDest_w_i,
  input  logic                   CP0_excOccur_w_i,
  input  logic [31:0]            CP0_excDestPC_w_i,
  output logic [31:0]            PCG_VAddr_o,
  output logic                   PCG_resp_valid_o,
  output logic                   PCG_resp_kill_o,
  output logic [31:0]            PCG_resp_VAddr_o,
  output logic [FETCH_WIDTH-1:0] PCG_resp_instEnable_o,
  output logic                   PCG_resp_needDS_o,
  output logic                   PCG_hasException_o,
  output logic [4:0]             PCG_ExcCode_o,
  output logic [2:0]             PCG_inflight_o
`ifdef PCG_PERF_CNT_EN
  ,
  output logic [31:0]            PCG_stallCnt_o,
  output logic [31:0]            PCG_redirCnt_o
`endif
);
  localparam int LW = $clog2(FETCH_WIDTH);
  localparam int P = LW + 2;
  localparam int EW = 32 + FETCH_WIDTH + 1;
  logic [31:0] pc, next_pc, aligned, head_pc;
  logic ds, redir, accept, exc, head_ds, head_dead;
  logic [LW-1:0] pos;
  logic [FETCH_WIDTH-1:0] en, head_en;
  logic [2:0] cnt;
  assign redir = CP0_excOccur_w_i | SBA_flush_w_i | BSC_isDiffRes_w_i;
  assign next_pc = CP0_excOccur_w_i ? CP0_excDestPC_w_i :
                   (SBA_flush_w_i | BSC_isDiffRes_w_i) ? BSC_correctDest_w_i : DSP_predictPC_i;
  assign aligned = line_align(pc, P);
  assign pos = pc[P-1:2];
  assign exc = |pc[1:0];
  assign inst_req = rst & !ID_stopFetch_i & !exc & (cnt < 3'(MAX_INFLIGHT));
  assign accept = inst_req & inst_index_ok;
  assign inst_wr = SRAM_READ;
  assign inst_size = LINE_SIZE;
  assign inst_wdata = ZERO_WORD;
  assign inst_index = aligned[INDEX_W-1:0];
  assign PCG_VAddr_o = aligned;
  assign PCG_hasException_o = exc;
  assign PCG_ExcCode_o = EXC_ADEL;
  assign PCG_inflight_o = cnt;
  // a delay-slot fetch only enables the slot at pos
  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_en
    assign en[g] = ds ? (pos == LW'(g)) : (pos <= LW'(g));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= START_PC;
      ds <= 1'b0;
    end else if (accept | redir) begin
      pc <= next_pc;
      ds <= DSP_needDelaySlot_i & !CP0_excOccur_w_i & !SBA_flush_w_i;
    end
  end
  fetch_inflight_fifo #(.WIDTH(EW), .DEPTH(MAX_INFLIGHT)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(accept),
    .din({pc, en, ds}),
    .din_dead(redir),
    .pop(inst_data_ok),
    .kill_all(redir),
    .dout({head_pc, head_en, head_ds}),
    .dout_dead(head_dead),
    .count(cnt)
  );
  assign PCG_resp_valid_o = inst_data_ok & (cnt != 3'd0);
  assign PCG_resp_kill_o = PCG_resp_valid_o & (head_dead | redir);
  assign PCG_resp_VAddr_o = PCG_resp_valid_o ? head_pc : 32'h0;
  assign PCG_resp_instEnable_o = PCG_resp_valid_o ? head_en : '0;
  assign PCG_resp_needDS_o = PCG_resp_valid_o & head_ds;
`ifdef PCG_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PCG_stallCnt_o <= '0;
      PCG_redirCnt_o <= '0;
    end else begin
      if (!inst_req && PCG_stallCnt_o != 32'hffffffff) PCG_stallCnt_o <= PCG_stallCnt_o + 32'h1;
      if (redir && PCG_redirCnt_o != 32'hffffffff) PCG_redirCnt_o <= PCG_redirCnt_o + 32'h1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed + randomized checks of fetch_pc_gen against a queue-based model
module tb_fetch_pc_gen;
  logic clk, rst;
  logic inst_req, inst_wr, inst_index_ok, inst_data_ok;
  logic [1:0] inst_size;
  logic [11:0] inst_index;
  logic [31:0] inst_wdata;
  logic stop, need_ds, sba, bsc, cp0;
  logic [31:0] predict, correct, exc_dest;
  logic [31:0] vaddr, resp_vaddr;
  logic resp_valid, resp_kill, resp_ds, has_exc;
  logic [3:0] resp_en;
  logic [4:0] exc_code;
  logic [2:0] inflight;
`ifdef PCG_PERF_CNT_EN
  logic [31:0] stall_cnt, redir_cnt;
`endif
  fetch_pc_gen dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_index(inst_index), .inst_wdata(inst_wdata),
    .inst_index_ok(inst_index_ok), .inst_data_ok(inst_data_ok),
    .ID_stopFetch_i(stop), .DSP_predictPC_i(predict), .DSP_needDelaySlot_i(need_ds),
    .SBA_flush_w_i(sba), .BSC_isDiffRes_w_i(bsc), .BSC_correctDest_w_i(correct),
    .CP0_excOccur_w_i(cp0), .CP0_excDestPC_w_i(exc_dest),
    .PCG_VAddr_o(vaddr), .PCG_resp_valid_o(resp_valid), .PCG_resp_kill_o(resp_kill),
    .PCG_resp_VAddr_o(resp_vaddr), .PCG_resp_instEnable_o(resp_en),
    .PCG_resp_needDS_o(resp_ds), .PCG_hasException_o(has_exc),
    .PCG_ExcCode_o(exc_code), .PCG_inflight_o(inflight)
`ifdef PCG_PERF_CNT_EN
    , .PCG_stallCnt_o(stall_cnt), .PCG_redirCnt_o(redir_cnt)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] pc;
    logic [3:0] en;
    logic ds;
    logic dead;
  } ent_t;
  ent_t q[$];
  logic [31:0] mpc;
  logic mds;
  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [3:0] m_mask(input logic [31:0] pc, input logic ds);
    int pos;
    logic [3:0] m;
    pos = int'((pc % 16) / 4);
    m = ds ? (4'b0001 << pos) : (4'b1111 << pos);
    return m;
  endfunction
  function automatic logic m_req();
    return rst && !stop && (mpc % 4 == 0) && q.size() < 2;
  endfunction
  task automatic look();
    logic [31:0] al;
    logic rv;
    #2;
    if (!rst) begin
      q.delete();
      mpc = 32'hbfc00000;
      mds = 1'b0;
    end
    al = mpc - (mpc % 16) + (mpc % 4);
    rv = inst_data_ok && q.size() > 0;
    chk("vaddr", vaddr, al);
    chk("index", 32'(inst_index), 32'(al[11:0]));
    chk("req", 32'(inst_req), 32'(m_req()));
    chk("has_exc", 32'(has_exc), 32'(mpc % 4 != 0));
    chk("inflight", 32'(inflight), 32'(q.size()));
    chk("resp_valid", 32'(resp_valid), 32'(rv));
    chk("const_bus", {inst_wr, inst_size, inst_wdata[28:0]}, 32'h3 << 29);
    if (rv) begin
      chk("resp_vaddr", resp_vaddr, q[0].pc);
      chk("resp_en", 32'(resp_en), 32'(q[0].en));
      chk("resp_ds", 32'(resp_ds), 32'(q[0].ds));
      chk("resp_kill", 32'(resp_kill), 32'(q[0].dead | sba | bsc | cp0));
    end
    if (inflight == 3'd0) chk("empty_resp", 32'(resp_valid), 32'd0);
  endtask
  task automatic tick();
    logic redir, acc;
    @(posedge clk);
    if (rst) begin
      redir = sba | bsc | cp0;
      acc = m_req() && inst_index_ok;
      if (inst_data_ok && q.size() > 0) void'(q.pop_front());
      if (redir) foreach (q[i]) q[i].dead = 1'b1;
      if (acc) q.push_back('{mpc, m_mask(mpc, mds), mds, redir});
      if (acc || redir) begin
        mpc = cp0 ? exc_dest : (sba || bsc) ? correct : predict;
        mds = need_ds && !cp0 && !sba;
      end
    end
    @(negedge clk);
  endtask
  task automatic step();
    look();
    tick();
  endtask
  function automatic logic [31:0] rand_pc(input int bad_pct);
    logic [31:0] p;
    p = {1'b1, 7'($urandom_range(3)), 24'($urandom)} & ~32'h3;
    if ($urandom_range(99) < bad_pct) p[1:0] = 2'($urandom_range(3, 1));
    return p;
  endfunction
  initial begin
    rst = 1'b0; stop = 0; need_ds = 0; sba = 0; bsc = 0; cp0 = 0;
    inst_index_ok = 0; inst_data_ok = 0;
    predict = 32'hbfc00010; correct = 0; exc_dest = 0;
    @(negedge clk); @(negedge clk);
    look();
    chk("rst_vaddr", vaddr, 32'hbfc00000);
    chk("rst_req", 32'(inst_req), 0);
    chk("rst_code", 32'(exc_code), 32'h4);
    tick();
    rst = 1'b1;
    inst_index_ok = 1;
    look();
    chk("t1_req", 32'(inst_req), 1);
    chk("t1_index", 32'(inst_index), 0);
    tick();
    inst_index_ok = 0; inst_data_ok = 1;
    look();
    chk("t1_vaddr", vaddr, 32'hbfc00010);
    chk("t1_en", 32'(resp_en), 32'hf);
    tick();
    predict = 32'h80000008; need_ds = 1; inst_index_ok = 1; inst_data_ok = 0;
    step();
    predict = 32'h80000020; need_ds = 0; inst_data_ok = 1;
    step();
    inst_index_ok = 0;
    look();
    chk("t2_ds_en", 32'(resp_en), 32'h4);
    chk("t2_ds", 32'(resp_ds), 1);
    tick();
    predict = 32'h80000008; inst_index_ok = 1; inst_data_ok = 0;
    step();
    predict = 32'h80000040; inst_data_ok = 1;
    step();
    inst_index_ok = 0;
    look();
    chk("t2_en", 32'(resp_en), 32'hc);
    chk("t2_nods", 32'(resp_ds), 0);
    tick();
    inst_data_ok = 0; inst_index_ok = 1;
    step(); step();
    inst_index_ok = 0;
    look();
    chk("t3_full", 32'(inflight), 2);
    chk("t3_req", 32'(inst_req), 0);
    tick();
    inst_data_ok = 1;
    step();
    inst_data_ok = 0;
    look();
    chk("t3_req_back", 32'(inst_req), 1);
    tick();
    inst_index_ok = 1;
    step();
    inst_index_ok = 0; sba = 1; correct = 32'h80001000;
    step();
    sba = 0; inst_data_ok = 1;
    look();
    chk("t4_kill0", 32'(resp_kill), 1);
    tick();
    look();
    chk("t4_kill1", 32'(resp_kill), 1);
    tick();
    inst_data_ok = 0; inst_index_ok = 1;
    step();
    inst_index_ok = 0; inst_data_ok = 1;
    look();
    chk("t4_fresh", 32'(resp_kill), 0);
    chk("t4_pc", resp_vaddr, 32'h80001000);
    tick();
    inst_data_ok = 0;
    cp0 = 1; exc_dest = 32'hbfc00380; sba = 1; bsc = 1; correct = 32'h80002000;
    step();
    cp0 = 0; sba = 0; bsc = 0;
    predict = 32'h80000002; inst_index_ok = 1;
    look();
    chk("t5_vec", vaddr, 32'hbfc00380);
    tick();
    look();
    chk("t5_exc", 32'(has_exc), 1);
    chk("t5_code", 32'(exc_code), 32'h4);
    chk("t5_req", 32'(inst_req), 0);
    tick();
    step();
    bsc = 1; correct = 32'h80003000;
    step();
    bsc = 0; inst_index_ok = 0; inst_data_ok = 1;
    look();
    chk("t5_clear", 32'(has_exc), 0);
    tick();
    inst_data_ok = 0; predict = 32'h80000100; inst_index_ok = 1;
    step(); step();
    inst_index_ok = 0;
    rst = 0;
    look();
    chk("t6_req", 32'(inst_req), 0);
    chk("t6_inflight", 32'(inflight), 0);
    tick();
    rst = 1; inst_data_ok = 1;
    look();
    chk("t6_stray", 32'(resp_valid), 0);
    tick();
    for (int n = 0; n < 3000; n++) begin
      rst = $urandom_range(249) != 0;
      stop = $urandom_range(5) == 0;
      inst_index_ok = $urandom_range(9) < 7;
      inst_data_ok = $urandom_range(1) == 1;
      need_ds = $urandom_range(3) == 0;
      cp0 = $urandom_range(23) == 0;
      sba = $urandom_range(13) == 0;
      bsc = $urandom_range(13) == 0;
      predict = rand_pc(5);
      correct = rand_pc(3);
      exc_dest = rand_pc(0);
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
